// File: rtl/bj_redirect_ctrl_pkg.sv
// Shared definitions for the branch/jump redirect controller.
// Holds the state encodings and the target-alignment helper.
package bj_redirect_ctrl_pkg;

    localparam int BJR_STATE_WIDTH = 2;

    localparam logic [BJR_STATE_WIDTH-1:0] BJR_IDLE  = 2'b00;
    localparam logic [BJR_STATE_WIDTH-1:0] BJR_REQ   = 2'b01;
    localparam logic [BJR_STATE_WIDTH-1:0] BJR_DRAIN = 2'b10;

    localparam int BUBBLE_W = 4;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/bj_redirect_ctrl_if.sv
// EX-side branch result and IF-side redirect handshake bundle.
// The master drives EX results and IF readiness; the slave is the redirect controller.
interface bj_redirect_ctrl_if #(
    parameter int XLEN = 32
) ();

    logic            ex_valid;
    logic            ex_is_bj;
    logic            ex_taken;
    logic [XLEN-1:0] ex_bj_addr;
    logic [XLEN-1:0] ex_pc;
    logic            redirect_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output ex_valid, ex_is_bj, ex_taken, ex_bj_addr, ex_pc, redirect_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  ex_valid, ex_is_bj, ex_taken, ex_bj_addr, ex_pc, redirect_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/bj_redirect_ctrl.sv
// Turns a resolved taken branch/jump into a held PC redirect request, front-end
// flushes and an EX stall that lasts until the post-redirect bubble has drained.
module bj_redirect_ctrl
    import bj_redirect_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bj_redirect_ctrl_if.slave     bus,
    output logic                  flush_if,
    output logic                  flush_id,
    output logic                  stall_ex,
    output logic                  misalign_exc,
    output logic [XLEN-1:0]       misalign_pc,
    output logic [CNT_W-1:0]      taken_cnt
);

    localparam logic [BUBBLE_W-1:0] BUBBLE_INIT = BUBBLE_W'(FLUSH_CYCLES - 1);

    logic [BJR_STATE_WIDTH-1:0] state_q, state_d;
    logic [BUBBLE_W-1:0]        bubble_q, bubble_d;
    logic [XLEN-1:0]            redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0]            misalign_pc_q, misalign_pc_d;
    logic                       misalign_exc_q, misalign_exc_d;
    logic [CNT_W-1:0]           taken_cnt_q, taken_cnt_d;

    logic trig_s;
    logic aligned_s;
    logic redirect_go_s;
    logic misalign_go_s;

    // Trigger qualification; EX inputs only matter while idle.
    always_comb begin
        trig_s        = bus.ex_valid & bus.ex_is_bj & bus.ex_taken & (state_q == BJR_IDLE);
        aligned_s     = is_word_aligned(bus.ex_bj_addr[1:0]);
        redirect_go_s = trig_s & aligned_s;
        misalign_go_s = trig_s & ~aligned_s;
    end

    // Next-state, bubble counter, captured target and counters.
    always_comb begin
        state_d        = state_q;
        bubble_d       = bubble_q;
        redirect_pc_d  = redirect_pc_q;
        misalign_pc_d  = misalign_pc_q;
        misalign_exc_d = misalign_go_s;
        taken_cnt_d    = taken_cnt_q;
        case (state_q)
            BJR_IDLE: begin
                if (redirect_go_s) begin
                    state_d       = BJR_REQ;
                    redirect_pc_d = bus.ex_bj_addr;
                end else if (misalign_go_s) begin
                    misalign_pc_d = bus.ex_pc;
                end else begin
                    state_d = BJR_IDLE;
                end
            end
            BJR_REQ: begin
                if (bus.redirect_ready) begin
                    state_d     = BJR_DRAIN;
                    bubble_d    = BUBBLE_INIT;
                    taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = BJR_REQ;
                end
            end
            BJR_DRAIN: begin
                if (bubble_q == {BUBBLE_W{1'b0}}) begin
                    state_d = BJR_IDLE;
                end else begin
                    bubble_d = bubble_q - {{(BUBBLE_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d  = BJR_IDLE;
                bubble_d = {BUBBLE_W{1'b0}};
            end
        endcase
    end

    // State registers; reset also drops any pending redirect or exception.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= BJR_IDLE;
            bubble_q       <= {BUBBLE_W{1'b0}};
            redirect_pc_q  <= {XLEN{1'b0}};
            misalign_pc_q  <= {XLEN{1'b0}};
            misalign_exc_q <= 1'b0;
            taken_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            bubble_q       <= bubble_d;
            redirect_pc_q  <= redirect_pc_d;
            misalign_pc_q  <= misalign_pc_d;
            misalign_exc_q <= misalign_exc_d;
            taken_cnt_q    <= taken_cnt_d;
        end
    end

    // Flushes fire in the trigger cycle itself so wrong-path fetches die immediately.
    always_comb begin
        bus.redirect_valid = (state_q == BJR_REQ);
        bus.redirect_pc    = redirect_pc_q;
        stall_ex           = (state_q != BJR_IDLE);
        flush_if           = redirect_go_s | (state_q != BJR_IDLE);
        flush_id           = redirect_go_s | (state_q == BJR_REQ);
        misalign_exc       = misalign_exc_q;
        misalign_pc        = misalign_pc_q;
        taken_cnt          = taken_cnt_q;
    end

endmodule

// File: doc/bj_redirect_ctrl.md
Name: bj_redirect_ctrl

Overview:
- Sequences resolved branch/jump results from the EX-stage bju into a PC redirect request to the fetch unit.
- Generates front-end flushes and stalls EX until the redirect is accepted and the bubble window has drained.
- Raises a misaligned-target exception instead of redirecting when the target is not 4-byte aligned.
- Sits between EX (bju output) and IF (PC mux).

Parameters:
- XLEN, 32, datapath/address width (matches `XLEN).
- FLUSH_CYCLES, 2, bubble cycles held after redirect acceptance (range 1..15).
- CNT_W, 32, width of the taken-redirect performance counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- ex_valid  in  1  EX holds a valid instruction this cycle
- ex_is_bj  in  1  EX instruction is branch/jump (same meaning as bju is_bj_inst)
- ex_taken  in  1  branch condition resolved taken (1 for jal/jalr)
- ex_bj_addr  in  XLEN  target address from bju
- ex_pc  in  XLEN  PC of the EX instruction
- redirect_ready  in  1  IF accepts redirect this cycle
- redirect_valid  out  1  redirect request to IF
- redirect_pc  out  XLEN  new fetch PC
- flush_if  out  1  kill IF/ID register contents
- flush_id  out  1  kill ID/EX register contents
- stall_ex  out  1  hold EX; no new branch presented
- misalign_exc  out  1  one-cycle exception pulse
- misalign_pc  out  XLEN  PC of the faulting branch
- taken_cnt  out  CNT_W  count of accepted redirects

Behaviour:
- Reset (rst_n=0 at posedge clk): state=IDLE; all outputs 0; taken_cnt=0. This holds mid-operation: a pending redirect is dropped.
- Trigger: trig = ex_valid & ex_is_bj & ex_taken & (state==IDLE).
- Not-taken or non-bj instructions produce no activity.
- States: IDLE, REQ, DRAIN.
- IDLE, trig, ex_bj_addr[1:0]==0:
  - Next state REQ.
  - redirect_pc <= ex_bj_addr; redirect_valid <= 1.
  - flush_if and flush_id are asserted combinationally in the trigger cycle (the wrong-path younger instructions are killed the same cycle).
- IDLE, trig, ex_bj_addr[1:0]!=0:
  - Stay IDLE; no redirect.
  - misalign_exc=1 for exactly one cycle (registered, the cycle after trig).
  - misalign_pc = ex_pc.
- REQ:
  - redirect_valid=1; stall_ex=1; flush_if=1; flush_id=1.
  - redirect_pc stays stable until accepted.
  - On redirect_ready: taken_cnt++ (wraps modulo 2^CNT_W), bubble counter <= FLUSH_CYCLES-1, next DRAIN, redirect_valid drops next cycle.
  - Accepted in the first REQ cycle if ready is already high, so minimum latency trig to acceptance is 1 cycle.
- DRAIN:
  - stall_ex=1; flush_if=1; flush_id=0; redirect_valid=0.
  - Bubble counter decrements each cycle; at 0 the next state is IDLE.
  - Total DRAIN length is exactly FLUSH_CYCLES cycles.
- stall_ex is 0 only in IDLE.
- Any ex_* activity while not IDLE is ignored: EX is stalled, and an upstream violation must not corrupt redirect_pc.
- Simultaneous misaligned trigger and reset: reset wins; no exception pulse.
- Handshake rule: once redirect_valid is raised, redirect_valid and redirect_pc do not change until redirect_ready is sampled high.

Decomposition:
- Shared package/defines (defines.v): state encodings BJR_IDLE/BJR_REQ/BJR_DRAIN (2-bit), BJR_STATE_WIDTH, reuse of `XLEN, `ZEROWORD, `TRUE/`FALSE.
- Single module; no sub-module needed. The bubble counter is an inline 4-bit down-counter.

Test Plan:
- Taken branch, aligned: ex_valid=1, ex_is_bj=1, ex_taken=1, ex_bj_addr=0x0000_1000, redirect_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x1000, accepted; taken_cnt=1; stall_ex high for 1+2 cycles, then IDLE.
- Ready back-pressure: same stimulus, redirect_ready low for 3 cycles -> redirect_valid and redirect_pc=0x1000 held stable for 4 cycles; flush_id high throughout REQ; DRAIN lasts 2 cycles after acceptance.
- Misaligned: ex_pc=0x200, ex_bj_addr=0x0000_1002, taken -> misalign_exc pulses 1 cycle with misalign_pc=0x200; redirect_valid stays 0; taken_cnt unchanged.
- Not taken: ex_is_bj=1, ex_taken=0 -> no outputs asserted; state stays IDLE.
- Reset mid-REQ: rst_n=0 for 1 cycle while redirect_ready=0 -> next cycle all outputs 0, taken_cnt=0; a subsequent branch to 0x40 redirects normally.
- Back-to-back: a second taken branch presented during DRAIN -> ignored, redirect_pc remains the first target. A branch presented in the first IDLE cycle after DRAIN is accepted; taken_cnt=2.
